// File: rtl/led_status_ctrl.sv
//============================================================================
// led_status_ctrl : heartbeat, pulse-stretched activity and core-reset LEDs.
// Optional feature: define LED_QUIET_EN to freeze all counters while quiet=1.
// Revision: 1.0
//============================================================================
`default_nettype none

module led_status_ctrl #(
  parameter int                 HB_WIDTH    = 23,
  parameter int                 NUM_ACT     = 2,
  parameter int                 STRETCH_LEN = 50000,
  parameter logic [NUM_ACT-1:0] ACT_IDLE    = {NUM_ACT{1'b1}}
) (
  input  logic               ext_clock,
  input  logic               reset,
  input  logic               quiet,
  input  logic [NUM_ACT-1:0] act_in,
  input  logic               core_reset_n,
  output logic               hb_led,
  output logic [NUM_ACT-1:0] act_led,
  output logic               reset_led
);

  localparam int                  C_CNT_W = $clog2(STRETCH_LEN + 1);
  localparam logic [C_CNT_W-1:0]  C_LOAD  = C_CNT_W'(STRETCH_LEN - 1);

  logic                w_freeze;
  logic [HB_WIDTH-1:0] r_hb_cnt;
  logic [NUM_ACT-1:0]  r_sync1;
  logic [NUM_ACT-1:0]  r_sync2;
  logic [NUM_ACT-1:0]  r_ref;
  logic [NUM_ACT-1:0]  w_edge;
  logic                r_reset_led;

`ifdef LED_QUIET_EN
  assign w_freeze = quiet;
`else
  // quiet is accepted for pin compatibility but has no effect in this build
  assign w_freeze = quiet & 1'b0;
`endif

  always_ff @(posedge ext_clock or posedge reset) begin
    if (reset) begin
      r_hb_cnt <= '0;
    end else if (!w_freeze) begin
      r_hb_cnt <= r_hb_cnt + HB_WIDTH'(1);
    end
  end

  assign hb_led = r_hb_cnt[HB_WIDTH-1];

  // Reference keeps tracking during freeze so no stale edge fires afterwards
  always_ff @(posedge ext_clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= ACT_IDLE;
      r_sync2 <= ACT_IDLE;
      r_ref   <= ACT_IDLE;
    end else begin
      r_sync1 <= act_in;
      r_sync2 <= r_sync1;
      r_ref   <= r_sync2;
    end
  end

  assign w_edge = r_sync2 ^ r_ref;

  generate
    for (genvar i = 0; i < NUM_ACT; i++) begin : g_act
      logic [C_CNT_W-1:0] r_cnt;
      logic               r_led;

      always_ff @(posedge ext_clock or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
          r_led <= 1'b0;
        end else if (!w_freeze) begin
          if (w_edge[i]) begin
            r_cnt <= C_LOAD;
            r_led <= 1'b1;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - C_CNT_W'(1);
          end else begin
            r_led <= 1'b0;
          end
        end
      end

      assign act_led[i] = r_led;
    end
  endgenerate

  always_ff @(posedge ext_clock or posedge reset) begin
    if (reset) begin
      r_reset_led <= 1'b0;
    end else begin
      r_reset_led <= ~core_reset_n;
    end
  end

  assign reset_led = r_reset_led;

endmodule

`default_nettype wire

// File: tb/tb_led_status_ctrl.sv
//============================================================================
// tb_led_status_ctrl : directed bench with a cycle-level behavioural model.
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_led_status_ctrl;

  localparam int         HB_W  = 4;
  localparam int         NACT  = 2;
  localparam int         SLEN  = 5;
  localparam logic [1:0] IDLE  = 2'b11;
`ifdef LED_QUIET_EN
  localparam bit         QUIET_ON = 1'b1;
`else
  localparam bit         QUIET_ON = 1'b0;
`endif

  logic            ext_clock = 1'b0;
  logic            reset     = 1'b1;
  logic            quiet     = 1'b0;
  logic [NACT-1:0] act_in    = IDLE;
  logic            core_reset_n = 1'b1;
  logic            hb_led;
  logic [NACT-1:0] act_led;
  logic            reset_led;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  led_status_ctrl #(
    .HB_WIDTH   (HB_W),
    .NUM_ACT    (NACT),
    .STRETCH_LEN(SLEN),
    .ACT_IDLE   (IDLE)
  ) dut (
    .ext_clock   (ext_clock),
    .reset       (reset),
    .quiet       (quiet),
    .act_in      (act_in),
    .core_reset_n(core_reset_n),
    .hb_led      (hb_led),
    .act_led     (act_led),
    .reset_led   (reset_led)
  );

  always #5 ext_clock = ~ext_clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Model: unfrozen-cycle count, remaining on-time per channel, input history
  int unsigned hb_n;
  int          on_left [NACT];
  logic [NACT-1:0] hist1, hist2, hist3;  // act_in samples at k-1, k-2, k-3
  logic        m_rl;

  always @(posedge ext_clock or posedge reset) begin
    if (reset) begin
      hb_n  = 0;
      m_rl  = 1'b0;
      hist1 = IDLE;
      hist2 = IDLE;
      hist3 = IDLE;
      for (int i = 0; i < NACT; i++) on_left[i] = 0;
    end else begin
      // a toggle sampled two edges ago takes effect now unless frozen
      for (int i = 0; i < NACT; i++) begin
        if (!(QUIET_ON && quiet)) begin
          if (hist2[i] != hist3[i]) on_left[i] = SLEN;
          else if (on_left[i] > 0) on_left[i] = on_left[i] - 1;
        end
      end
      hist3 = hist2;
      hist2 = hist1;
      hist1 = act_in;
      if (!(QUIET_ON && quiet)) hb_n++;
      m_rl = !core_reset_n;
    end
  end

  always @(negedge ext_clock) begin
    if (cmp_on) begin
      logic [NACT-1:0] exp_act;
      for (int i = 0; i < NACT; i++) exp_act[i] = (on_left[i] > 0);
      check("model_hb",  {31'd0, hb_led},    {31'd0, ((hb_n % (2**HB_W)) >= (2**(HB_W-1)))});
      check("model_act", {30'd0, act_led},   {30'd0, exp_act});
      check("model_rst", {31'd0, reset_led}, {31'd0, m_rl});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ext_clock);
      #2;
    end
  endtask

  initial begin
    // Reset with idle inputs
    tick(3);
    check("rst_hb",  {31'd0, hb_led},    32'd0);
    check("rst_act", {30'd0, act_led},   32'd0);
    check("rst_rl",  {31'd0, reset_led}, 32'd0);
    cmp_on = 1'b1;
    reset  = 1'b0;

    // Heartbeat: rises at cycle 8, falls at 16; no activity pulse after reset
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      check("hb_cycle", {31'd0, hb_led}, {31'd0, (c >= 8 && c < 16)});
      if (c <= 10) check("no_spurious", {30'd0, act_led}, 32'd0);
    end

    // Stretch: one-cycle low pulse on channel 0 gives loads at n+2 and n+3
    act_in[0] = 1'b0;
    tick(1);
    act_in[0] = 1'b1;
    tick(1);
    check("str_n1", {30'd0, act_led}, 32'd0);
    tick(1);
    check("str_n2", {30'd0, act_led}, 32'd1);
    tick(5);
    check("str_n7", {30'd0, act_led}, 32'd1);
    tick(1);
    check("str_n8", {30'd0, act_led}, 32'd0);

    // Retrigger: channel 1 toggles every 3 cycles; loads at m+2,5,8,11
    for (int k = 0; k < 4; k++) begin
      act_in[1] = ~act_in[1];
      tick(3);
      check("retrig_on", {31'd0, act_led[1]}, 32'd1);
    end
    tick(4);
    check("retrig_m15", {31'd0, act_led[1]}, 32'd1);
    tick(1);
    check("retrig_m16", {31'd0, act_led[1]}, 32'd0);

    // Reset LED mid-stretch, then asynchronous reset mid-stretch
    act_in[0] = 1'b0;
    tick(3);
    core_reset_n = 1'b0;
    #1 check("rl_lag", {31'd0, reset_led}, 32'd0);
    tick(1);
    check("rl_set", {31'd0, reset_led}, 32'd1);
    check("rl_str", {31'd0, act_led[0]}, 32'd1);
    core_reset_n = 1'b1;
    tick(1);
    check("rl_clr", {31'd0, reset_led}, 32'd0);
    core_reset_n = 1'b0;
    tick(1);
    reset = 1'b1;
    #1;
    check("async_act", {30'd0, act_led},   32'd0);
    check("async_rl",  {31'd0, reset_led}, 32'd0);
    act_in       = IDLE;
    core_reset_n = 1'b1;
    tick(2);
    reset = 1'b0;

    // Quiet window on edges 5..24 with toggles and reset-LED activity inside
    for (int c = 1; c <= 30; c++) begin
      tick(1);
      if (QUIET_ON) begin
        check("q_hb",  {31'd0, hb_led},  {31'd0, (c >= 28)});
        check("q_act", {30'd0, act_led}, 32'd0);
      end else begin
        check("nq_hb",   {31'd0, hb_led},     {31'd0, ((c % 16) >= 8)});
        check("nq_act0", {31'd0, act_led[0]}, {31'd0, (c >= 13 && c <= 17)});
        check("nq_act1", {31'd0, act_led[1]}, {31'd0, (c >= 24 && c <= 28)});
      end
      check("q_rl", {31'd0, reset_led}, {31'd0, (c == 8 || c == 9)});
      if (c == 4)  quiet = 1'b1;
      if (c == 24) quiet = 1'b0;
      if (c == 10) act_in[0] = 1'b0;
      if (c == 21) act_in[1] = 1'b0;
      if (c == 7)  core_reset_n = 1'b0;
      if (c == 9)  core_reset_n = 1'b1;
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_status_ctrl.md
# led_status_ctrl

Parametrised board-status indicator for the CW305 DesignStart top level. It replaces the hard-wired clock-alive counter and the XOR-based UART LED with three outputs: a heartbeat LED, a per-channel pulse-stretched activity LED array and a registered core-reset LED. All counters can be frozen during a capture window so the block contributes no switching noise to power traces. It sits in the `ext_clock` domain beside the M3 subsystem and drives the LED pins directly.

## Interface
- `HB_WIDTH`, 23: heartbeat counter width; heartbeat period is 2^HB_WIDTH cycles.
- `NUM_ACT`, 2: number of activity channels (≥1).
- `STRETCH_LEN`, 50000: activity LED on-time in cycles (≥1); the counter width is $clog2(STRETCH_LEN+1).
- `ACT_IDLE`, {NUM_ACT{1'b1}}: idle level of each `act_in` bit, used as the reset value of its synchroniser and edge-reference flops.

Ports:
- `ext_clock`, in, 1: the block's only clock.
- `reset`, in, 1: asynchronous, active-high.
- `quiet`, in, 1: capture-window flag, synchronous to `ext_clock` (GPIO trigger).
- `act_in`, in, NUM_ACT: asynchronous activity sources (e.g. UART rxd/txd).
- `core_reset_n`, in, 1: M3 reset status, synchronous to `ext_clock`.
- `hb_led`, out, 1: heartbeat.
- `act_led`, out, NUM_ACT: stretched activity per channel.
- `reset_led`, out, 1: high while the core is held in reset.

## Operation
- Reset values: `hb_led`=0, `act_led`=0, `reset_led`=0, heartbeat counter=0, stretch counters=0. Synchroniser and edge-reference flops take the value of `ACT_IDLE`.
- Heartbeat: an HB_WIDTH-bit up-counter increments by 1 per cycle and wraps from all-ones to 0. `hb_led` = counter MSB.
- Activity, per channel i:
  - `act_in[i]` goes through a 2-flop synchroniser.
  - Edge = synchroniser output ≠ edge-reference flop. Both rising and falling edges count.
  - The reference flop updates every cycle.
  - On an edge: counter ← STRETCH_LEN−1 and `act_led[i]` ← 1. An edge that arrives while the LED is already lit reloads the counter (retrigger).
  - With no edge: if counter≠0, decrement; if counter=0, `act_led[i]` ← 0.
  - Channels are fully independent.
- `reset_led` is the registered value of ~`core_reset_n`.
- Quiet freeze (only with the Configuration macro defined). While `quiet`=1:
  - The heartbeat and stretch counters hold.
  - `hb_led` and `act_led` hold their values.
  - Detected edges are discarded.
  - Reference flops keep tracking, so no stale edge fires when `quiet` falls.
  - `reset_led` always updates.

## Timing
- `act_in[i]` toggles before edge n → `act_led[i]` is high after edge n+2 (3-cycle latency). It then stays high exactly STRETCH_LEN cycles after the last load, excluding frozen cycles.
- `hb_led` toggles every 2^(HB_WIDTH−1) unfrozen cycles.
- `reset_led` lags `core_reset_n` by 1 cycle.
- `quiet` takes effect on the first edge at which it is sampled high. Counting resumes on the first edge at which it is sampled low.
- If an edge and `quiet`=1 occur in the same cycle, `quiet` wins and the edge is dropped.
- If `reset` is asserted mid-stretch, outputs clear immediately (asynchronous). No spurious edge is generated on release when the inputs are at ACT_IDLE.

## Configuration
- `LED_QUIET_EN` defined: quiet freeze as described above.
- Not defined: `quiet` is ignored and all counters run freely. The port remains present.

## Test plan
- Reset: assert `reset` with `act_in`=2'b11. All outputs are 0. Release reset. No `act_led` pulse occurs within 10 cycles.
- Heartbeat (HB_WIDTH=4): after reset, `hb_led` rises at cycle 8, falls at cycle 16, and repeats with a period of 16.
- Stretch (STRETCH_LEN=5): a 1-cycle low pulse on `act_in[0]` gives two edges. `act_led[0]` is high 3 cycles after the first edge and low 5 cycles after the second edge's load. `act_led[1]` stays 0.
- Retrigger (STRETCH_LEN=5): toggle `act_in[1]` every 3 cycles, 4 times. `act_led[1]` stays continuously high, then falls 5 cycles after the last load.
- Quiet (LED_QUIET_EN, HB_WIDTH=4):
  - Raise `quiet` at cycle 5 for 20 cycles. `hb_led` rises at cycle 28.
  - An `act_in` toggle inside the window lights nothing, and no edge fires when `quiet` falls.
  - Without the macro, `hb_led` rises at cycle 8.
- Reset LED: drive `core_reset_n` 1→0→1. `reset_led` follows as 0→1→0 with a 1-cycle delay. This holds both during `quiet`=1 and mid-stretch.
